clock_monitor: RTL and testbench
================================

Name: clock_monitor

Overview:
- Sequential checker for the output of the clock generator: samples a monitored clock (`mon_in`) in the system `clk` domain.
- Measures period and high time in `clk` cycles, counts rising edges, flags stalls and glitches.
- Sits beside the clock generator in the catalog; used in-system and by benches to self-check generated clocks.

Parameters:
- CNT_WIDTH, 16, width of the period/high-time counters and outputs.
- TIMEOUT, 64, number of `clk` cycles without a detected rising edge before `stalled` asserts; must be ≥2 and ≤2^CNT_WIDTH-1.
- MIN_HALF, 2, minimum legal high or low duration in `clk` cycles; shorter durations set `glitch`.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  monitoring enable; low forces IDLE.
- mon_in  in  1  monitored clock, treated as asynchronous data.
- clear_flags  in  1  one-cycle pulse clearing the sticky `glitch`.
- period  out  CNT_WIDTH  last measured rising-to-rising period in `clk` cycles.
- high_time  out  CNT_WIDTH  last measured high duration in `clk` cycles.
- meas_valid  out  1  one-cycle pulse when `period` updates.
- stalled  out  1  no rising edge for TIMEOUT cycles.
- glitch  out  1  sticky, half-period shorter than MIN_HALF seen.
- edge_count  out  16  rising edges detected while enabled; wraps at 65535→0.

Behaviour:
- Reset (synchronous, active-high): all outputs 0, all counters 0, synchronizer flops 0, state IDLE.
- Synchronizer: s1<=mon_in, s2<=s1, s3<=s2; it runs regardless of enable. rise = s2&~s3; fall = ~s2&s3.
  - Latency: `mon_in` first sampled high at edge k → rise true in cycle after k+1 → outputs update at edge k+2.
- State machine states: IDLE, WAIT_FIRST, MEASURE, STALLED.
- IDLE:
  - enable=1 → WAIT_FIRST, with cnt=0.
  - Counters held at 0; `period`/`high_time` hold last values; `meas_valid`=0, `stalled`=0.
- WAIT_FIRST:
  - On rise → MEASURE: cnt<=0, hi_cnt<=1, edge_count+1. No `meas_valid`.
  - Otherwise cnt++.
- MEASURE, each cycle:
  - rise: period<=cnt+1 (saturating at 2^CNT_WIDTH-1); meas_valid<=1; cnt<=0; hi_cnt<=1; edge_count+1. If lo_cnt<MIN_HALF, glitch<=1.
  - fall: high_time<=hi_cnt; lo_cnt<=1. If hi_cnt<MIN_HALF, glitch<=1.
  - Otherwise: cnt++; hi_cnt++ if s2, else lo_cnt++. All counters saturate.
- Timeout (WAIT_FIRST or MEASURE): if no rise and cnt==TIMEOUT-1, then stalled<=1 and state → STALLED.
- STALLED:
  - `stalled` holds 1; `meas_valid`=0.
  - On rise: stalled<=0, edge_count+1, cnt<=0, hi_cnt<=1, → MEASURE. No `meas_valid` on this edge; the next rise yields a valid period.
- enable=0 in any state → IDLE next cycle; `stalled` cleared; `glitch` and `edge_count` retained.
- glitch set and clear_flags in the same cycle: set wins.
- Example: 5 high / 5 low `mon_in` gives period=10 and high_time=5. The first high_time latches on the first fall after entering MEASURE.
- `meas_valid` is never high two consecutive cycles.
- Reset mid-measurement returns to IDLE immediately. No output update from a partial measurement.

Test Plan:
- Nominal: enable=1, mon_in toggling 5/5 cycles → no meas_valid on the first detected rise. From the second rise: period=10, high_time=5, meas_valid one-cycle pulse every 10 cycles. edge_count increments per rise; stalled=0, glitch=0.
- Duty: mon_in 3 high / 7 low → period=10, high_time=3. With MIN_HALF=4 the same stimulus → glitch=1 after the first fall in MEASURE.
- Stall: 5/5 clock, then mon_in held low → stalled=1 exactly TIMEOUT (64) cycles after the last rise-detect cycle, meas_valid stays 0. Resume toggling → stalled=0 on the first rise, meas_valid on the second rise with period=10.
- Glitch: one-cycle high pulse inserted in a 5/5 clock → glitch=1 sticky. clear_flags pulse → 0. clear_flags coincident with a new glitch → glitch stays 1.
- Enable/reset: enable=0 mid-run → IDLE next cycle, meas_valid=0, stalled=0, period holds 10. Re-enable → first rise gives no meas_valid. reset=1 mid-run → all outputs 0 at the next edge.
- Wrap/saturate: 65536 rising edges → edge_count wraps to 0. TIMEOUT=2^CNT_WIDTH-1 with mon_in held low → cnt saturates, then stalled=1.

Source files
------------

// File: rtl/clock_monitor.sv
// Clock monitor: samples mon_in in the clk domain, measures its period and high time,
// counts rising edges, and flags stalls and short half-periods.
//
// state      | meaning
// IDLE       | monitoring disabled, counters held at 0
// WAIT_FIRST | enabled, hunting for a reference rising edge
// MEASURE    | reference edge seen, every rise yields a period
// STALLED    | no rising edge within TIMEOUT cycles
module clock_monitor #(
  parameter int CNT_WIDTH = 16,
  parameter int TIMEOUT   = 64,
  parameter int MIN_HALF  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 mon_in,
  input  logic                 clear_flags,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 meas_valid,
  output logic                 stalled,
  output logic                 glitch,
  output logic [15:0]          edge_count
);

  typedef enum logic [1:0] {IDLE, WAIT_FIRST, MEASURE, STALLED} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] HALF_MIN = CNT_WIDTH'(MIN_HALF);

  state_t state, state_nxt;
  logic s1, s2, s3;
  logic rise, fall;
  logic glitch_set;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic [CNT_WIDTH-1:0] hi_cnt, hi_cnt_nxt;
  logic [CNT_WIDTH-1:0] lo_cnt, lo_cnt_nxt;
  logic [CNT_WIDTH-1:0] period_nxt, high_time_nxt;
  logic                 meas_valid_nxt, stalled_nxt, glitch_nxt;
  logic [15:0]          edge_count_nxt;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    hi_cnt_nxt     = hi_cnt;
    lo_cnt_nxt     = lo_cnt;
    period_nxt     = period;
    high_time_nxt  = high_time;
    meas_valid_nxt = 1'b0;
    stalled_nxt    = stalled;
    edge_count_nxt = edge_count;
    glitch_set     = 1'b0;

    if (!enable) begin
      state_nxt   = IDLE;
      stalled_nxt = 1'b0;
      cnt_nxt     = '0;
      hi_cnt_nxt  = '0;
      lo_cnt_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt   = WAIT_FIRST;
          stalled_nxt = 1'b0;
          cnt_nxt     = '0;
          hi_cnt_nxt  = '0;
          lo_cnt_nxt  = '0;
        end
        WAIT_FIRST: begin
          if (rise) begin
            state_nxt      = MEASURE;
            cnt_nxt        = '0;
            hi_cnt_nxt     = CNT_ONE;
            lo_cnt_nxt     = '0;
            edge_count_nxt = edge_count + 16'd1;
          end else begin
            cnt_nxt = sat_inc(cnt);
            if (cnt == CNT_LAST) begin
              stalled_nxt = 1'b1;
              state_nxt   = STALLED;
            end
          end
        end
        MEASURE: begin
          if (rise) begin
            period_nxt     = sat_inc(cnt);
            meas_valid_nxt = 1'b1;
            cnt_nxt        = '0;
            hi_cnt_nxt     = CNT_ONE;
            edge_count_nxt = edge_count + 16'd1;
            glitch_set     = (lo_cnt < HALF_MIN);
          end else begin
            // cnt spans the whole period, so it also advances on the fall cycle
            cnt_nxt = sat_inc(cnt);
            if (fall) begin
              high_time_nxt = hi_cnt;
              lo_cnt_nxt    = CNT_ONE;
              glitch_set    = (hi_cnt < HALF_MIN);
            end else if (s2) begin
              hi_cnt_nxt = sat_inc(hi_cnt);
            end else begin
              lo_cnt_nxt = sat_inc(lo_cnt);
            end
            if (cnt == CNT_LAST) begin
              stalled_nxt = 1'b1;
              state_nxt   = STALLED;
            end
          end
        end
        STALLED: begin
          if (rise) begin
            state_nxt      = MEASURE;
            stalled_nxt    = 1'b0;
            cnt_nxt        = '0;
            hi_cnt_nxt     = CNT_ONE;
            lo_cnt_nxt     = '0;
            edge_count_nxt = edge_count + 16'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    glitch_nxt = (glitch & ~clear_flags) | glitch_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      cnt        <= '0;
      hi_cnt     <= '0;
      lo_cnt     <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      stalled    <= 1'b0;
      glitch     <= 1'b0;
      edge_count <= '0;
    end else begin
      state      <= state_nxt;
      s1         <= mon_in;
      s2         <= s1;
      s3         <= s2;
      cnt        <= cnt_nxt;
      hi_cnt     <= hi_cnt_nxt;
      lo_cnt     <= lo_cnt_nxt;
      period     <= period_nxt;
      high_time  <= high_time_nxt;
      meas_valid <= meas_valid_nxt;
      stalled    <= stalled_nxt;
      glitch     <= glitch_nxt;
      edge_count <= edge_count_nxt;
    end
  end

endmodule

// File: tb/tb_clock_monitor.sv
// Bench for clock_monitor: event-timestamp reference model feeding a scoreboard,
// plus variants with MIN_HALF=4 and a 4-bit counter with TIMEOUT=15.
module tb_clock_monitor;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic reset = 1'b1, enable = 1'b0, mon_in = 1'b0, clear_flags = 1'b0;

  logic [15:0] period, high_time, edge_count;
  logic        meas_valid, stalled, glitch;
  logic [15:0] period_mh, high_time_mh, edge_count_mh;
  logic        meas_valid_mh, stalled_mh, glitch_mh;
  logic [3:0]  period_sat, high_time_sat;
  logic [15:0] edge_count_sat;
  logic        meas_valid_sat, stalled_sat, glitch_sat;

  clock_monitor dut (
    .clk(clk), .reset(reset), .enable(enable), .mon_in(mon_in), .clear_flags(clear_flags),
    .period(period), .high_time(high_time), .meas_valid(meas_valid),
    .stalled(stalled), .glitch(glitch), .edge_count(edge_count));

  clock_monitor #(.MIN_HALF(4)) dut_mh (
    .clk(clk), .reset(reset), .enable(enable), .mon_in(mon_in), .clear_flags(clear_flags),
    .period(period_mh), .high_time(high_time_mh), .meas_valid(meas_valid_mh),
    .stalled(stalled_mh), .glitch(glitch_mh), .edge_count(edge_count_mh));

  clock_monitor #(.CNT_WIDTH(4), .TIMEOUT(15)) dut_sat (
    .clk(clk), .reset(reset), .enable(enable), .mon_in(mon_in), .clear_flags(clear_flags),
    .period(period_sat), .high_time(high_time_sat), .meas_valid(meas_valid_sat),
    .stalled(stalled_sat), .glitch(glitch_sat), .edge_count(edge_count_sat));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int cyc;
    int per;
    int hi;
  } exp_t;
  exp_t sb[$];

  // Reference model: works on timestamps of detected edges rather than counters
  int t = 0;
  bit mon_at[$];
  bit started = 1'b0;
  bit m_on, m_track, m_stall, m_glitch, m_glitch4, m_meas;
  int m_ref, m_rise, m_fall, m_edges, m_period, m_high;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit en, input bit mon, input bit clr);
    bit s2, s3, rise, fall, gs, gs4;
    int d;
    s2 = (t >= 2) ? mon_at[t-2] : 1'b0;
    s3 = (t >= 3) ? mon_at[t-3] : 1'b0;
    rise = s2 && !s3;
    fall = !s2 && s3;
    gs = 1'b0;
    gs4 = 1'b0;
    m_meas = 1'b0;
    if (r) begin
      if (t >= 1) mon_at[t-1] = 1'b0;
      if (t >= 2) mon_at[t-2] = 1'b0;
      m_on = 0; m_track = 0; m_stall = 0; m_glitch = 0; m_glitch4 = 0;
      m_edges = 0; m_period = 0; m_high = 0;
    end else begin
      if (!en) begin
        m_on = 0; m_track = 0; m_stall = 0;
      end else if (!m_on) begin
        m_on = 1; m_track = 0; m_stall = 0; m_ref = t;
      end else if (rise) begin
        m_edges = (m_edges + 1) % 65536;
        if (m_track) begin
          m_meas = 1'b1;
          m_period = t - m_rise;
          d = t - m_fall;
          gs = (d < 2);
          gs4 = (d < 4);
          sb.push_back('{cyc: t, per: m_period, hi: m_high});
        end
        m_track = 1; m_rise = t; m_ref = t; m_stall = 0;
      end else begin
        if (fall && m_track) begin
          d = t - m_rise;
          m_high = d;
          gs = (d < 2);
          gs4 = (d < 4);
          m_fall = t;
        end
        if (!m_stall && (t - m_ref == TO)) begin
          m_stall = 1; m_track = 0;
        end
      end
      m_glitch  = (m_glitch && !clr) || gs;
      m_glitch4 = (m_glitch4 && !clr) || gs4;
    end
    mon_at.push_back(r ? 1'b0 : mon);
    t++;
  endtask

  task automatic drive(input bit r, input bit en, input bit mon, input bit clr);
    @(negedge clk);
    reset = r;
    enable = en;
    mon_in = mon;
    clear_flags = clr;
    model_step(r, en, mon, clr);
    started = 1'b1;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_clock(input int hi, input int lo, input int n, input bit en = 1'b1);
    repeat (n) begin
      repeat (hi) drive(1'b0, en, 1'b1, 1'b0);
      repeat (lo) drive(1'b0, en, 1'b0, 1'b0);
    end
  endtask

  initial begin : monitor
    exp_t e;
    bit exp_mv;
    int cur;
    forever begin
      @(posedge clk);
      #1;
      if (started) begin
        cur = t - 1;
        exp_mv = (sb.size() > 0) && (sb[0].cyc == cur);
        check("meas_valid", meas_valid, exp_mv);
        check("meas_valid_mh", meas_valid_mh, exp_mv);
        if (exp_mv) begin
          e = sb.pop_front();
          check("sb_period", period, e.per);
          check("sb_high_time", high_time, e.hi);
        end
        check("period", period, m_period);
        check("high_time", high_time, m_high);
        check("stalled", stalled, m_stall);
        check("glitch", glitch, m_glitch);
        check("edge_count", edge_count, m_edges);
        check("glitch_mh", glitch_mh, m_glitch4);
        check("period_mh", period_mh, m_period);
        check("high_time_mh", high_time_mh, m_high);
        check("stalled_mh", stalled_mh, m_stall);
        check("edge_count_mh", edge_count_mh, m_edges);
      end
    end
  end

  initial begin : stimulus
    repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0);

    // 4-bit instance hunts with TIMEOUT=15 while mon_in stays low
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      settle();
      if (k == 14) check("sat_stalled_early", stalled_sat, 0);
      if (k == 15) begin
        check("sat_stalled_timeout", stalled_sat, 1);
        check("sat_period", period_sat, 0);
        check("sat_high_time", high_time_sat, 0);
        check("sat_meas_valid", meas_valid_sat, 0);
        check("sat_glitch", glitch_sat, 0);
        check("sat_edge_count", edge_count_sat, 0);
      end
    end
    repeat (60) drive(1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    check("wait_first_stalled", stalled, 1);

    // nominal 5/5
    run_clock(5, 5, 10);
    settle();
    check("nominal_period", period, 10);
    check("nominal_high", high_time, 5);
    check("nominal_edges", edge_count, 10);

    // duty 3/7
    run_clock(3, 7, 8);
    settle();
    check("duty_period", period, 10);
    check("duty_high", high_time, 3);
    check("duty_glitch_min2", glitch, 0);
    check("duty_glitch_min4", glitch_mh, 1);
    drive(1'b0, 1'b1, 1'b0, 1'b1);

    // stall then resume
    run_clock(5, 5, 4);
    repeat (80) drive(1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    check("stall_flag", stalled, 1);
    run_clock(5, 5, 4);
    settle();
    check("resume_stalled", stalled, 0);
    check("resume_period", period, 10);

    // one-cycle high pulse inside the low phase
    run_clock(5, 5, 3);
    repeat (5) drive(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (2) drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (2) drive(1'b0, 1'b1, 1'b0, 1'b0);
    run_clock(5, 5, 3);
    settle();
    check("glitch_sticky", glitch, 1);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    settle();
    check("glitch_cleared", glitch, 0);
    run_clock(5, 5, 2);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (2) drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    settle();
    check("glitch_set_beats_clear", glitch, 1);

    // enable drop, re-enable, then reset mid-run
    run_clock(5, 5, 3);
    run_clock(3, 3, 2, 1'b0);
    settle();
    check("disabled_stalled", stalled, 0);
    check("disabled_meas_valid", meas_valid, 0);
    check("disabled_period_hold", period, 10);
    run_clock(5, 5, 3);
    repeat (2) drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    settle();
    check("reset_period", period, 0);
    check("reset_high", high_time, 0);
    check("reset_edges", edge_count, 0);
    check("reset_glitch", glitch, 0);
    run_clock(5, 5, 3);

    // randomized segments
    for (int seg = 0; seg < 250; seg++) begin
      int hi, lo, sel;
      bit en;
      sel = int'($urandom_range(0, 99));
      hi = int'($urandom_range(1, 9));
      lo = int'($urandom_range(1, 9));
      if (sel < 5) lo = int'($urandom_range(50, 90));
      en = !(sel >= 5 && sel < 9);
      for (int i = 0; i < hi; i++)
        drive((sel == 99) && (i == 0), en, 1'b1, $urandom_range(0, 49) == 0);
      for (int i = 0; i < lo; i++)
        drive(1'b0, en, 1'b0, $urandom_range(0, 49) == 0);
    end

    repeat (5) drive(1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
